// File: rtl/z16_mem_arbiter_if.sv
// Bus bundle between the Z16 core ports, the arbiter and the unified RAM.
// Latency: none (wires only).
// Backpressure: request side holds req/addr/data until its gnt; memory side has none.
// Signal names carry the arbiter's point of view: i_* flow into the arbiter, o_* flow out.
//   fetch port : i_if_req, i_if_addr, o_if_gnt, o_if_rvalid, o_if_rdata
//   data port  : i_d_req, i_d_we, i_d_addr, i_d_wdata, o_d_gnt, o_d_rvalid, o_d_rdata
//   memory     : o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, i_mem_rdata
//   status     : o_busy
interface z16_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt;
  logic              o_if_rvalid;
  logic [DATA_W-1:0] o_if_rdata;

  logic              i_d_req;
  logic              i_d_we;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_wdata;
  logic              o_d_gnt;
  logic              o_d_rvalid;
  logic [DATA_W-1:0] o_d_rdata;

  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  logic              o_busy;

  // Arbiter side.
  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata,
    output o_d_gnt, o_d_rvalid, o_d_rdata,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata,
    output o_busy
  );

  // Environment side (core ports plus RAM).
  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata,
    input  o_d_gnt, o_d_rvalid, o_d_rdata,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata,
    input  o_busy
  );
endinterface

// File: rtl/z16_mem_arbiter.sv
// Shares one single-port synchronous RAM between the Z16 fetch port and load/store port.
// Latency: gnt to rvalid MEM_LAT+2 cycles for reads; writes occupy 2 cycles (gnt, access).
// Backpressure: one access outstanding; requesters hold req/addr/data until gnt, data port
//   has priority but yields to a waiting fetch after MAX_DATA_RUN consecutive data grants.
// Ports: i_clk, i_rst (sync, active-low), io_bus (z16_mem_arbiter_if.slave: both request
//   ports, memory strobe/address/data, read-data returns and o_busy).
module z16_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MEM_LAT      = 1,   // 1..8
  parameter int MAX_DATA_RUN = 2    // 1..7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  z16_mem_arbiter_if.slave io_bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  logic [1:0]        r_state;
  logic [2:0]        r_run;       // consecutive data grants while a fetch waits
  logic [3:0]        r_lat;       // read latency countdown
  logic              r_own_d;     // owner of the access in flight: 1 = data, 0 = fetch
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_if_rvalid;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_idle;
  logic w_f_win;
  logic w_d_win;

  assign w_idle  = (r_state == S_IDLE);
  // Fetch only wins when the data port is quiet or has used up its run allowance.
  assign w_f_win = w_idle && io_bus.i_if_req &&
                   (!io_bus.i_d_req || (r_run == 3'(MAX_DATA_RUN)));
  assign w_d_win = w_idle && io_bus.i_d_req && !w_f_win;

  // Grants are combinational and must never escape while reset is held.
  assign io_bus.o_if_gnt    = w_f_win && i_rst;
  assign io_bus.o_d_gnt     = w_d_win && i_rst;
  assign io_bus.o_if_rvalid = r_if_rvalid;
  assign io_bus.o_if_rdata  = r_if_rdata;
  assign io_bus.o_d_rvalid  = r_d_rvalid;
  assign io_bus.o_d_rdata   = r_d_rdata;
  assign io_bus.o_mem_en    = (r_state == S_ACCESS);
  assign io_bus.o_mem_we    = r_we;
  assign io_bus.o_mem_addr  = r_addr;
  assign io_bus.o_mem_wdata = r_wdata;
  assign io_bus.o_busy      = !w_idle;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_run       <= 3'd0;
      r_lat       <= 4'd0;
      r_own_d     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_f_win) begin
            r_state <= S_ACCESS;
            r_own_d <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= io_bus.i_if_addr;
          end else if (w_d_win) begin
            r_state <= S_ACCESS;
            r_own_d <= 1'b1;
            r_we    <= io_bus.i_d_we;
            r_addr  <= io_bus.i_d_addr;
            r_wdata <= io_bus.i_d_wdata;
          end
          if (!io_bus.i_if_req || w_f_win) begin
            r_run <= 3'd0;
          end else if (w_d_win) begin
            r_run <= r_run + 3'd1;
          end
        end
        S_ACCESS: begin
          if (r_we) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
            r_lat   <= 4'(MEM_LAT);
          end
        end
        S_WAIT: begin
          // The counter holds 1 in the cycle the RAM presents its data, so it
          // lands on 0 exactly as the data is captured.
          r_lat <= r_lat - 4'd1;
          if (r_lat == 4'd1) begin
            r_state <= S_IDLE;
            if (r_own_d) begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= io_bus.i_mem_rdata;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= io_bus.i_mem_rdata;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z16_mem_arbiter.sv
// Directed bench for z16_mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=4), each with
// a behavioural RAM, and per-port queues of expected read data drained on every rvalid.
// Stimulus driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_z16_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1;
  logic rst4;
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] qif1[$];
  logic [15:0] qd1[$];
  logic [15:0] qif4[$];
  logic [15:0] qd4[$];

  z16_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b1 ();
  z16_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b4 ();

  z16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .MAX_DATA_RUN(2)) dut1 (
    .i_clk  (clk),
    .i_rst  (rst1),
    .io_bus (b1)
  );

  z16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4), .MAX_DATA_RUN(2)) dut4 (
    .i_clk  (clk),
    .i_rst  (rst4),
    .io_bus (b4)
  );

  // Initial RAM contents: a fixed pattern, with the word the fetch test expects at 0x0010.
  function automatic logic [15:0] pat(input logic [15:0] a);
    if (a == 16'h0010) return 16'hA5C3;
    return (a << 3) ^ 16'h5A3C ^ {a[7:0], a[15:8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // RAM for the MEM_LAT=1 instance: data valid the cycle after the strobe, garbage otherwise.
  bit          wr1 [0:4095];
  logic [15:0] wd1 [0:4095];
  logic [15:0] rd1;
  logic [11:0] a1;
  assign a1 = b1.o_mem_addr[11:0];
  always @(posedge clk) begin
    if (b1.o_mem_en === 1'b1 && b1.o_mem_we === 1'b1) begin
      wr1[a1] <= 1'b1;
      wd1[a1] <= b1.o_mem_wdata;
    end
    rd1 <= (b1.o_mem_en === 1'b1 && b1.o_mem_we === 1'b0) ?
           (wr1[a1] ? wd1[a1] : pat({4'h0, a1})) : 16'hDEAD;
  end
  assign b1.i_mem_rdata = rd1;

  // RAM for the MEM_LAT=4 instance: four-stage read pipeline.
  bit          wr4 [0:4095];
  logic [15:0] wd4 [0:4095];
  logic [15:0] p4 [0:3];
  logic [11:0] a4;
  assign a4 = b4.o_mem_addr[11:0];
  always @(posedge clk) begin
    if (b4.o_mem_en === 1'b1 && b4.o_mem_we === 1'b1) begin
      wr4[a4] <= 1'b1;
      wd4[a4] <= b4.o_mem_wdata;
    end
    p4[0] <= (b4.o_mem_en === 1'b1 && b4.o_mem_we === 1'b0) ?
             (wr4[a4] ? wd4[a4] : pat({4'h0, a4})) : 16'hDEAD;
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign b4.i_mem_rdata = p4[3];

  // Scoreboard: every rvalid must belong to a port with an outstanding read.
  always @(negedge clk) begin
    if (b1.o_if_rvalid === 1'b1) begin
      chk("if1_rvalid_owned", 32'(qif1.size() != 0), 1);
      if (qif1.size() != 0) chk("if1_rdata", b1.o_if_rdata, qif1.pop_front());
    end
    if (b1.o_d_rvalid === 1'b1) begin
      chk("d1_rvalid_owned", 32'(qd1.size() != 0), 1);
      if (qd1.size() != 0) chk("d1_rdata", b1.o_d_rdata, qd1.pop_front());
    end
    if (b4.o_if_rvalid === 1'b1) begin
      chk("if4_rvalid_owned", 32'(qif4.size() != 0), 1);
      if (qif4.size() != 0) chk("if4_rdata", b4.o_if_rdata, qif4.pop_front());
    end
    if (b4.o_d_rvalid === 1'b1) begin
      chk("d4_rvalid_owned", 32'(qd4.size() != 0), 1);
      if (qd4.size() != 0) chk("d4_rdata", b4.o_d_rdata, qd4.pop_front());
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ifa;
    logic [15:0] da;
    bit          inc_if;
    bit          inc_d;
    int          ng;
    int          gseq [0:5];
    int          exp_seq [0:5];

    exp_seq = '{1, 1, 0, 1, 1, 0};   // 1 = data grant, 0 = fetch grant
    gseq    = '{-1, -1, -1, -1, -1, -1};

    // Reset with both ports requesting on both instances.
    rst1 = 1'b0; rst4 = 1'b0;
    b1.i_if_req = 1'b1; b1.i_if_addr = 16'h0; b1.i_d_req = 1'b1; b1.i_d_we = 1'b0;
    b1.i_d_addr = 16'h0; b1.i_d_wdata = 16'h0;
    b4.i_if_req = 1'b1; b4.i_if_addr = 16'h0; b4.i_d_req = 1'b1; b4.i_d_we = 1'b0;
    b4.i_d_addr = 16'h0; b4.i_d_wdata = 16'h0;
    for (int k = 0; k < 2; k++) begin
      adv();
      @(negedge clk);
      chk("rst_if_gnt", b1.o_if_gnt, 0);
      chk("rst_d_gnt", b1.o_d_gnt, 0);
      chk("rst_mem_en", b1.o_mem_en, 0);
      chk("rst_busy", b1.o_busy, 0);
      chk("rst4_gnts", {b4.o_if_gnt, b4.o_d_gnt}, 0);
    end
    chk("rst_if_rdata", b1.o_if_rdata, 0);
    chk("rst_d_rdata", b1.o_d_rdata, 0);
    chk("rst_rvalids", {b1.o_if_rvalid, b1.o_d_rvalid}, 0);
    chk("rst_mem_out", {b1.o_mem_we, b1.o_mem_addr, b1.o_mem_wdata}, 0);

    adv();
    rst1 = 1'b1; rst4 = 1'b1;
    b1.i_if_req = 1'b0; b1.i_d_req = 1'b0; b4.i_if_req = 1'b0; b4.i_d_req = 1'b0;
    @(negedge clk);
    chk("idle_busy", b1.o_busy, 0);

    // Single fetch from 0x0010, MEM_LAT=1.
    adv();
    b1.i_if_req = 1'b1; b1.i_if_addr = 16'h0010;
    @(negedge clk);
    chk("f_gnt_T", b1.o_if_gnt, 1);
    qif1.push_back(16'hA5C3);
    adv();
    b1.i_if_req = 1'b0;
    @(negedge clk);
    chk("f_mem_en_T1", b1.o_mem_en, 1);
    chk("f_mem_addr_T1", b1.o_mem_addr, 16'h0010);
    chk("f_mem_we_T1", b1.o_mem_we, 0);
    adv();
    @(negedge clk);
    chk("f_rvalid_T2", b1.o_if_rvalid, 0);
    chk("f_mem_en_T2", b1.o_mem_en, 0);
    adv();
    @(negedge clk);
    chk("f_rvalid_T3", b1.o_if_rvalid, 1);
    chk("f_rdata_T3", b1.o_if_rdata, 16'hA5C3);
    chk("f_d_rvalid_T3", b1.o_d_rvalid, 0);
    repeat (7) adv();
    @(negedge clk);
    chk("f_rdata_hold_T10", b1.o_if_rdata, 16'hA5C3);
    chk("f_rvalid_T10", b1.o_if_rvalid, 0);

    // Store 0xBEEF to 0x0100, then load it straight back.
    adv();
    b1.i_d_req = 1'b1; b1.i_d_we = 1'b1; b1.i_d_addr = 16'h0100; b1.i_d_wdata = 16'hBEEF;
    @(negedge clk);
    chk("st_gnt_T", b1.o_d_gnt, 1);
    adv();
    b1.i_d_req = 1'b0; b1.i_d_we = 1'b0;
    @(negedge clk);
    chk("st_mem_en_T1", b1.o_mem_en, 1);
    chk("st_mem_we_T1", b1.o_mem_we, 1);
    chk("st_mem_addr_T1", b1.o_mem_addr, 16'h0100);
    chk("st_mem_wdata_T1", b1.o_mem_wdata, 16'hBEEF);
    adv();
    b1.i_d_req = 1'b1; b1.i_d_we = 1'b0; b1.i_d_addr = 16'h0100;
    @(negedge clk);
    chk("st_regnt_T2", b1.o_d_gnt, 1);
    chk("st_no_rvalid_T2", b1.o_d_rvalid, 0);
    qd1.push_back(16'hBEEF);
    adv();
    b1.i_d_req = 1'b0;
    repeat (2) adv();
    @(negedge clk);
    chk("ld_rvalid_T5", b1.o_d_rvalid, 1);
    chk("ld_rdata_T5", b1.o_d_rdata, 16'hBEEF);

    // Both ports requesting continuously: data, data, fetch, repeated.
    ifa = 16'h0200; da = 16'h0300; inc_if = 1'b0; inc_d = 1'b0; ng = 0;
    adv();
    b1.i_if_req = 1'b1; b1.i_if_addr = ifa;
    b1.i_d_req = 1'b1; b1.i_d_we = 1'b0; b1.i_d_addr = da;
    @(negedge clk);
    for (int c = 0; c < 40 && ng < 6; c++) begin
      if (c != 0) begin
        adv();
        if (inc_if) ifa = ifa + 16'd1;
        if (inc_d) da = da + 16'd1;
        inc_if = 1'b0; inc_d = 1'b0;
        b1.i_if_addr = ifa; b1.i_d_addr = da;
        @(negedge clk);
      end
      if (b1.o_if_gnt === 1'b1 && b1.o_d_gnt === 1'b1) chk("arb_double_gnt", 2, 1);
      if (b1.o_if_gnt === 1'b1) begin
        gseq[ng] = 0; ng++; qif1.push_back(pat(ifa)); inc_if = 1'b1;
      end else if (b1.o_d_gnt === 1'b1) begin
        gseq[ng] = 1; ng++; qd1.push_back(pat(da)); inc_d = 1'b1;
      end
    end
    chk("arb_grant_count", ng, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("arb_gnt%0d", k), gseq[k], exp_seq[k]);
    adv();
    b1.i_if_req = 1'b0; b1.i_d_req = 1'b0;
    repeat (4) adv();
    @(negedge clk);
    chk("arb_if_drained", qif1.size(), 0);
    chk("arb_d_drained", qd1.size(), 0);

    // Fetch alone, request held: grants every 3 cycles, rvalid alongside each later grant.
    ifa = 16'h0400;
    adv();
    b1.i_if_req = 1'b1; b1.i_if_addr = ifa;
    @(negedge clk);
    chk("fh_gnt0", b1.o_if_gnt, 1);
    qif1.push_back(pat(ifa));
    for (int k = 1; k < 3; k++) begin
      adv();
      ifa = ifa + 16'd1; b1.i_if_addr = ifa;
      @(negedge clk);
      chk($sformatf("fh_nogntA%0d", k), b1.o_if_gnt, 0);
      adv();
      @(negedge clk);
      chk($sformatf("fh_nogntB%0d", k), b1.o_if_gnt, 0);
      adv();
      @(negedge clk);
      chk($sformatf("fh_gnt%0d", k), b1.o_if_gnt, 1);
      chk($sformatf("fh_rvalid%0d", k), b1.o_if_rvalid, 1);
      qif1.push_back(pat(ifa));
    end
    adv();
    b1.i_if_req = 1'b0;
    repeat (3) adv();
    @(negedge clk);
    chk("fh_drained", qif1.size(), 0);

    // MEM_LAT=4: reset during WAIT abandons the load; next load returns at gnt+6.
    adv();
    b4.i_d_req = 1'b1; b4.i_d_we = 1'b0; b4.i_d_addr = 16'h0020;
    @(negedge clk);
    chk("l4_gnt_T", b4.o_d_gnt, 1);
    adv();
    b4.i_d_req = 1'b0;
    @(negedge clk);
    chk("l4_mem_en_T1", b4.o_mem_en, 1);
    adv();
    @(negedge clk);
    chk("l4_busy_wait", b4.o_busy, 1);
    adv();
    rst4 = 1'b0;
    @(negedge clk);
    adv();
    rst4 = 1'b1;
    @(negedge clk);
    chk("l4_rst_busy", b4.o_busy, 0);
    chk("l4_rst_rvalid", b4.o_d_rvalid, 0);
    chk("l4_rst_rdata", b4.o_d_rdata, 0);
    for (int k = 0; k < 6; k++) begin
      adv();
      @(negedge clk);
      chk($sformatf("l4_abandon_rvalid%0d", k), b4.o_d_rvalid, 0);
    end
    adv();
    b4.i_d_req = 1'b1; b4.i_d_addr = 16'h0030;
    @(negedge clk);
    chk("l4b_gnt", b4.o_d_gnt, 1);
    qd4.push_back(pat(16'h0030));
    adv();
    b4.i_d_req = 1'b0;
    @(negedge clk);
    chk("l4b_mem_addr", b4.o_mem_addr, 16'h0030);
    repeat (4) adv();
    @(negedge clk);
    chk("l4b_rvalid_g5", b4.o_d_rvalid, 0);
    adv();
    @(negedge clk);
    chk("l4b_rvalid_g6", b4.o_d_rvalid, 1);
    chk("l4b_rdata_g6", b4.o_d_rdata, pat(16'h0030));
    adv();
    @(negedge clk);
    chk("l4_drained", qd4.size() + qif4.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
